hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 16 +
 rtl/forward_unit.sv | 23 ++
 rtl/hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// forwarding select codes and the default MDU watchdog limit.
package hazard_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } hz_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int MDU_TIMEOUT_DEF = 64;

endpackage

// File: rtl/forward_unit.sv
// Operand bypass select for one EX source register.
// The MEM result is younger than the WB result, so it wins when both match.
module forward_unit
  import hazard_pkg::*;
(
  input  logic [4:0] rs_i,
  input  logic [4:0] rd_m_i,
  input  logic       reg_write_m_i,
  input  logic [4:0] rd_w_i,
  input  logic       reg_write_w_i,
  output logic [1:0] fwd_o
);

  always_comb begin
    fwd_o = FWD_RF;
    if (reg_write_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs_i)) begin
      fwd_o = FWD_MEM;
    end else if (reg_write_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs_i)) begin
      fwd_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use stall, branch flush and
// multi-cycle MDU sequencing with a sticky watchdog and stall/flush counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MDU_TIMEOUT = MDU_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1_D,
  input  logic [4:0]  rs2_D,
  input  logic [4:0]  rs1_E,
  input  logic [4:0]  rs2_E,
  input  logic [4:0]  rd_E,
  input  logic        MemRead_E,
  input  logic        mdu_req_E,
  input  logic        PCSrc_E,
  input  logic [4:0]  rd_M,
  input  logic        RegWrite_M,
  input  logic [4:0]  rd_W,
  input  logic        RegWrite_W,
  input  logic        mdu_done,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushM,
  output logic [1:0]  ForwardA_E,
  output logic [1:0]  ForwardB_E,
  output logic        mdu_start,
  output logic        mdu_timeout,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam int              WD_W   = $clog2(MDU_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(MDU_TIMEOUT);

  hz_state_e       state_q, state_d;
  logic [WD_W-1:0] wdog_q, wdog_d, wdog_inc;
  logic            timeout_q, timeout_d;
  logic [31:0]     stall_cnt_q, stall_cnt_d;
  logic [31:0]     flush_cnt_q, flush_cnt_d;
  logic            load_use;
  logic            stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, start;

  forward_unit u_fwd_a (
    .rs_i          (rs1_E),
    .rd_m_i        (rd_M),
    .reg_write_m_i (RegWrite_M),
    .rd_w_i        (rd_W),
    .reg_write_w_i (RegWrite_W),
    .fwd_o         (ForwardA_E)
  );

  forward_unit u_fwd_b (
    .rs_i          (rs2_E),
    .rd_m_i        (rd_M),
    .reg_write_m_i (RegWrite_M),
    .rd_w_i        (rd_W),
    .reg_write_w_i (RegWrite_W),
    .fwd_o         (ForwardB_E)
  );

  assign load_use = MemRead_E && (rd_E != 5'd0) && ((rd_E == rs1_D) || (rd_E == rs2_D));
  assign wdog_inc = (wdog_q == WD_MAX) ? wdog_q : wdog_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    wdog_d    = wdog_q;
    timeout_d = timeout_q;
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_e   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    flush_m   = 1'b0;
    start     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (PCSrc_E) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (load_use) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
        // A flushed EX slot holds no real MDU instruction, so never launch it.
        if (mdu_req_E && !flush_e) begin
          start   = 1'b1;
          state_d = ST_BUSY;
          wdog_d  = '0;
        end
      end
      ST_BUSY: begin
        if (mdu_done) begin
          state_d = ST_IDLE;
        end else begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          flush_m = 1'b1;
        end
        wdog_d = wdog_inc;
        if (wdog_inc == WD_MAX) timeout_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controls are forced low while reset is held so the pipeline sees no hazards.
  assign StallF    = reset & stall_f;
  assign StallD    = reset & stall_d;
  assign StallE    = reset & stall_e;
  assign FlushD    = reset & flush_d;
  assign FlushE    = reset & flush_e;
  assign FlushM    = reset & flush_m;
  assign mdu_start = reset & start;

  assign stall_cnt_d = stall_cnt_q + {31'd0, StallF};
  assign flush_cnt_d = flush_cnt_q + {31'd0, FlushE};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      wdog_q      <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wdog_q      <= wdog_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mdu_timeout = timeout_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a behavioural model compared every
// negative clock edge, plus directed vectors with literal expectations.
module tb_hazard_ctrl;

  localparam int MDU_TO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic        MemRead_E, mdu_req_E, PCSrc_E, RegWrite_M, RegWrite_W, mdu_done;
  logic        StallF, StallD, StallE, FlushD, FlushE, FlushM;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic        mdu_start, mdu_timeout;
  logic [31:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.MDU_TIMEOUT(MDU_TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .rs1_D       (rs1_D),
    .rs2_D       (rs2_D),
    .rs1_E       (rs1_E),
    .rs2_E       (rs2_E),
    .rd_E        (rd_E),
    .MemRead_E   (MemRead_E),
    .mdu_req_E   (mdu_req_E),
    .PCSrc_E     (PCSrc_E),
    .rd_M        (rd_M),
    .RegWrite_M  (RegWrite_M),
    .rd_W        (rd_W),
    .RegWrite_W  (RegWrite_W),
    .mdu_done    (mdu_done),
    .StallF      (StallF),
    .StallD      (StallD),
    .StallE      (StallE),
    .FlushD      (FlushD),
    .FlushE      (FlushE),
    .FlushM      (FlushM),
    .ForwardA_E  (ForwardA_E),
    .ForwardB_E  (ForwardB_E),
    .mdu_start   (mdu_start),
    .mdu_timeout (mdu_timeout),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic sf, sd, se, fd, fe, fm, st;
  } exp_t;

  bit          m_busy = 1'b0;
  int          m_wd = 0;
  bit          m_to = 1'b0;
  logic [31:0] m_scnt = '0;
  logic [31:0] m_fcnt = '0;

  function automatic logic [1:0] fwd_exp(input logic [4:0] rs);
    if (RegWrite_M && rd_M != 5'd0 && rd_M == rs) return 2'b10;
    if (RegWrite_W && rd_W != 5'd0 && rd_W == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    logic lu;
    e  = '0;
    lu = MemRead_E && (rd_E != 5'd0) && ((rd_E == rs1_D) || (rd_E == rs2_D));
    if (!reset) return e;
    if (m_busy) begin
      if (!mdu_done) begin
        e.sf = 1'b1; e.sd = 1'b1; e.se = 1'b1; e.fm = 1'b1;
      end
    end else begin
      e.fd = PCSrc_E;
      e.fe = PCSrc_E | lu;
      e.sf = lu & ~PCSrc_E;
      e.sd = lu & ~PCSrc_E;
      e.st = mdu_req_E & ~(PCSrc_E | lu);
    end
    return e;
  endfunction

  exp_t upd_e;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy = 1'b0; m_wd = 0; m_to = 1'b0; m_scnt = '0; m_fcnt = '0;
    end else begin
      upd_e = expect_now();
      if (upd_e.sf) m_scnt = m_scnt + 32'd1;
      if (upd_e.fe) m_fcnt = m_fcnt + 32'd1;
      if (m_busy) begin
        if (m_wd < MDU_TO) m_wd++;
        if (m_wd == MDU_TO) m_to = 1'b1;
        if (mdu_done) m_busy = 1'b0;
      end else if (upd_e.st) begin
        m_busy = 1'b1;
        m_wd   = 0;
      end
    end
  end

  exp_t ce;
  always @(negedge clk) begin
    ce = expect_now();
    chk("cmp_StallF", 32'(StallF), 32'(ce.sf));
    chk("cmp_StallD", 32'(StallD), 32'(ce.sd));
    chk("cmp_StallE", 32'(StallE), 32'(ce.se));
    chk("cmp_FlushD", 32'(FlushD), 32'(ce.fd));
    chk("cmp_FlushE", 32'(FlushE), 32'(ce.fe));
    chk("cmp_FlushM", 32'(FlushM), 32'(ce.fm));
    chk("cmp_mdu_start", 32'(mdu_start), 32'(ce.st));
    chk("cmp_ForwardA", 32'(ForwardA_E), 32'(fwd_exp(rs1_E)));
    chk("cmp_ForwardB", 32'(ForwardB_E), 32'(fwd_exp(rs2_E)));
    chk("cmp_timeout", 32'(mdu_timeout), 32'(m_to));
    chk("cmp_stall_cnt", stall_cnt, m_scnt);
    chk("cmp_flush_cnt", flush_cnt, m_fcnt);
  end

  // ---------------- directed stimulus ----------------
  task automatic clear_inputs();
    rs1_D = '0; rs2_D = '0; rs1_E = '0; rs2_E = '0; rd_E = '0; rd_M = '0; rd_W = '0;
    MemRead_E = 1'b0; mdu_req_E = 1'b0; PCSrc_E = 1'b0;
    RegWrite_M = 1'b0; RegWrite_W = 1'b0; mdu_done = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rwm;
    logic [4:0] rdm;
    logic       rww;
    logic [4:0] rdw;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [1:0] fa;
    logic [1:0] fb;
  } fwd_vec_t;

  fwd_vec_t fv[5];
  logic [31:0] s0, f0;

  initial begin
    fv[0] = '{1'b1, 5'd3, 1'b1, 5'd3, 5'd3, 5'd3, 2'b10, 2'b10};
    fv[1] = '{1'b0, 5'd3, 1'b1, 5'd3, 5'd3, 5'd0, 2'b01, 2'b00};
    fv[2] = '{1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00};
    fv[3] = '{1'b1, 5'd4, 1'b0, 5'd9, 5'd9, 5'd4, 2'b00, 2'b10};
    fv[4] = '{1'b0, 5'd4, 1'b1, 5'd9, 5'd9, 5'd4, 2'b01, 2'b00};

    clear_inputs();
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_StallF", 32'(StallF), 0);
    chk("rst_FlushE", 32'(FlushE), 0);
    chk("rst_mdu_start", 32'(mdu_start), 0);
    chk("rst_timeout", 32'(mdu_timeout), 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    reset = 1'b1;
    tick();

    // forwarding priority and x0 exclusion
    RegWrite_M = 1'b1; rd_M = 5'd5; RegWrite_W = 1'b1; rd_W = 5'd5; rs1_E = 5'd5; rs2_E = 5'd3;
    #1;
    chk("fwdA_mem_wins", 32'(ForwardA_E), 2);
    chk("fwdB_none", 32'(ForwardB_E), 0);
    rd_M = 5'd0;
    #1;
    chk("fwdA_wb_when_rdM0", 32'(ForwardA_E), 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      RegWrite_M = fv[i].rwm; rd_M = fv[i].rdm; RegWrite_W = fv[i].rww; rd_W = fv[i].rdw;
      rs1_E = fv[i].rs1; rs2_E = fv[i].rs2;
      #1;
      chk($sformatf("fwd_vec%0d_A", i), 32'(ForwardA_E), 32'(fv[i].fa));
      chk($sformatf("fwd_vec%0d_B", i), 32'(ForwardB_E), 32'(fv[i].fb));
      tick();
    end
    clear_inputs();

    // load-use stall, one cycle
    MemRead_E = 1'b1; rd_E = 5'd7; rs2_D = 5'd7; rs1_D = 5'd1;
    #1;
    chk("lu_StallF", 32'(StallF), 1);
    chk("lu_StallD", 32'(StallD), 1);
    chk("lu_FlushE", 32'(FlushE), 1);
    chk("lu_FlushD", 32'(FlushD), 0);
    tick();
    MemRead_E = 1'b0;
    #1;
    chk("lu_gone_StallF", 32'(StallF), 0);
    tick();
    MemRead_E = 1'b1; rd_E = 5'd0; rs1_D = 5'd0; rs2_D = 5'd0;
    #1;
    chk("lu_x0_StallF", 32'(StallF), 0);
    tick();
    // branch overrides load-use
    MemRead_E = 1'b1; rd_E = 5'd7; rs2_D = 5'd7; PCSrc_E = 1'b1;
    #1;
    chk("br_FlushD", 32'(FlushD), 1);
    chk("br_FlushE", 32'(FlushE), 1);
    chk("br_StallF", 32'(StallF), 0);
    chk("br_StallD", 32'(StallD), 0);
    tick();
    clear_inputs();
    // MDU request squashed by a branch, done in IDLE ignored
    mdu_req_E = 1'b1; PCSrc_E = 1'b1;
    #1;
    chk("req_flushed_start", 32'(mdu_start), 0);
    tick();
    clear_inputs();
    mdu_done = 1'b1;
    #1;
    chk("idle_done_StallE", 32'(StallE), 0);
    chk("idle_done_StallF", 32'(StallF), 0);
    tick();
    clear_inputs();

    // MDU op: launch at cycle 0, done at cycle 5
    s0 = stall_cnt; f0 = flush_cnt;
    mdu_req_E = 1'b1;
    #1;
    chk("mdu_c0_start", 32'(mdu_start), 1);
    chk("mdu_c0_StallE", 32'(StallE), 0);
    tick();
    for (int c = 1; c <= 4; c++) begin
      clear_inputs();
      if (c == 2) begin
        PCSrc_E = 1'b1; MemRead_E = 1'b1; rd_E = 5'd7; rs2_D = 5'd7;
      end
      if (c == 3) mdu_req_E = 1'b1;
      #1;
      chk($sformatf("mdu_c%0d_StallE", c), 32'(StallE), 1);
      chk($sformatf("mdu_c%0d_FlushM", c), 32'(FlushM), 1);
      chk($sformatf("mdu_c%0d_start", c), 32'(mdu_start), 0);
      chk($sformatf("mdu_c%0d_FlushE", c), 32'(FlushE), 0);
      chk($sformatf("mdu_c%0d_FlushD", c), 32'(FlushD), 0);
      tick();
    end
    clear_inputs();
    mdu_done = 1'b1;
    #1;
    chk("mdu_c5_StallE", 32'(StallE), 0);
    chk("mdu_c5_FlushM", 32'(FlushM), 0);
    chk("mdu_c5_StallF", 32'(StallF), 0);
    tick();
    mdu_done = 1'b0;
    #1;
    chk("mdu_stall_cnt_delta", stall_cnt - s0, 4);
    chk("mdu_flush_cnt_delta", flush_cnt - f0, 0);
    chk("mdu_after_StallF", 32'(StallF), 0);
    tick();

    // watchdog: no done, limit of 8 BUSY cycles
    mdu_req_E = 1'b1;
    tick();
    mdu_req_E = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("wd_busy%0d_timeout", k), 32'(mdu_timeout), 0);
      chk($sformatf("wd_busy%0d_StallE", k), 32'(StallE), 1);
      tick();
    end
    for (int k = 9; k <= 11; k++) begin
      chk($sformatf("wd_busy%0d_timeout", k), 32'(mdu_timeout), 1);
      chk($sformatf("wd_busy%0d_StallE", k), 32'(StallE), 1);
      tick();
    end
    mdu_done = 1'b1;
    tick();
    mdu_done = 1'b0;
    chk("wd_sticky_timeout", 32'(mdu_timeout), 1);
    chk("wd_idle_StallE", 32'(StallE), 0);
    tick();

    // reset in the middle of an MDU op
    mdu_req_E = 1'b1;
    tick();
    mdu_req_E = 1'b0;
    tick();
    #1 reset = 1'b0;
    #1;
    chk("rb_StallF", 32'(StallF), 0);
    chk("rb_StallD", 32'(StallD), 0);
    chk("rb_StallE", 32'(StallE), 0);
    chk("rb_FlushM", 32'(FlushM), 0);
    chk("rb_mdu_start", 32'(mdu_start), 0);
    chk("rb_timeout", 32'(mdu_timeout), 0);
    chk("rb_stall_cnt", stall_cnt, 0);
    chk("rb_flush_cnt", flush_cnt, 0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("rel_StallE", 32'(StallE), 0);
    chk("rel_mdu_start", 32'(mdu_start), 0);
    tick();
    chk("rel2_StallE", 32'(StallE), 0);
    chk("rel2_mdu_start", 32'(mdu_start), 0);
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
